// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch, decode and execute for the
// 8-bit CPU datapath. Outputs depend on the current state; IR is used only
// to pick the ALU operation and the A/B load destination.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic       write,
  output logic [3:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel
);

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_D3,
    S_OP4, S_OP5,                // MAR<-PC, PC_Inc: shared operand fetch
    S_LDI6,                      // immediate load
    S_DIR6, S_LDD7, S_LDD8,      // direct address fetch, wait, load
    S_STA7, S_STB7, S_STR7,      // store of A, B or ALU result
    S_ALU4,
    S_BT4, S_BT5, S_BT6,         // taken branch
    S_BNT4                       // not-taken branch skips its operand
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic       alu_valid;
  logic [3:0] alu_code;
  logic       alu_dest_b;
  logic       is_branch;
  logic       branch_taken;
  logic       is_mem_op;

  // State register; reset forces F0 immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_F0;
    else       state_reg <= state_next;
  end

  // Opcode decode: ALU selection and branch condition from flags.
  always_comb begin
    alu_valid    = 1'b1;
    alu_code     = 4'd0;
    alu_dest_b   = (IR >= 8'h4C);
    is_branch    = 1'b1;
    branch_taken = 1'b0;
    is_mem_op    = 1'b0;
    case (IR)
      8'h42: alu_code = 4'd0;
      8'h43: alu_code = 4'd1;
      8'h44: alu_code = 4'd2;
      8'h45: alu_code = 4'd3;
      8'h46: alu_code = 4'd4;
      8'h48: alu_code = 4'd5;
      8'h4A: alu_code = 4'd6;
      8'h4B: alu_code = 4'd7;
      8'h4C: alu_code = 4'd8;
      8'h4D: alu_code = 4'd9;
      8'h4E: alu_code = 4'd10;
      8'h4F: alu_code = 4'd11;
      default: alu_valid = 1'b0;
    endcase
    case (IR)
      8'h20: branch_taken = 1'b1;
      8'h21: branch_taken =  CCR_Result[3];
      8'h22: branch_taken = ~CCR_Result[3];
      8'h23: branch_taken =  CCR_Result[2];
      8'h24: branch_taken = ~CCR_Result[2];
      8'h25: branch_taken =  CCR_Result[1];
      8'h26: branch_taken = ~CCR_Result[1];
      8'h27: branch_taken =  CCR_Result[0];
      8'h28: branch_taken = ~CCR_Result[0];
      default: is_branch = 1'b0;
    endcase
    case (IR)
      8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h98: is_mem_op = 1'b1;
      default: is_mem_op = 1'b0;
    endcase
  end

  // Next-state logic; flags only matter on the D3 transition.
  always_comb begin
    state_next = S_F0;
    case (state_reg)
      S_F0: state_next = S_F1;
      S_F1: state_next = S_F2;
      S_F2: state_next = S_D3;
      S_D3: begin
        if (is_mem_op)      state_next = S_OP4;
        else if (alu_valid) state_next = S_ALU4;
        else if (is_branch) state_next = branch_taken ? S_BT4 : S_BNT4;
        else                state_next = S_F0;
      end
      S_OP4: state_next = S_OP5;
      S_OP5: state_next = (IR == 8'h86 || IR == 8'h88) ? S_LDI6 : S_DIR6;
      S_DIR6: begin
        case (IR)
          8'h87, 8'h89: state_next = S_LDD7;
          8'h96:        state_next = S_STA7;
          8'h97:        state_next = S_STB7;
          8'h98:        state_next = S_STR7;
          default:      state_next = S_F0;
        endcase
      end
      S_LDD7: state_next = S_LDD8;
      S_BT4:  state_next = S_BT5;
      S_BT5:  state_next = S_BT6;
      default: state_next = S_F0;
    endcase
  end

  // Moore outputs; all held at zero while reset is asserted.
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    write    = 1'b0;
    ALU_Sel  = 4'd0;
    Bus1_Sel = 2'b00;
    Bus2_Sel = 2'b00;
    if (!reset) begin
      case (state_reg)
        S_F0, S_OP4, S_BT4: begin
          Bus1_Sel = 2'b00;
          Bus2_Sel = 2'b01;
          MAR_Load = 1'b1;
        end
        S_F1, S_OP5, S_BNT4: PC_Inc = 1'b1;
        S_F2: begin
          Bus2_Sel = 2'b10;
          IR_Load  = 1'b1;
        end
        S_LDI6, S_LDD8: begin
          Bus2_Sel = 2'b10;
          A_Load   = (IR == 8'h86 || IR == 8'h87);
          B_Load   = ~(IR == 8'h86 || IR == 8'h87);
        end
        S_DIR6: begin
          Bus2_Sel = 2'b10;
          MAR_Load = 1'b1;
        end
        S_STA7: begin
          Bus1_Sel = 2'b01;
          Bus2_Sel = 2'b01;
          write    = 1'b1;
        end
        S_STB7: begin
          Bus1_Sel = 2'b10;
          Bus2_Sel = 2'b01;
          write    = 1'b1;
        end
        S_STR7: begin
          Bus2_Sel = 2'b00;
          write    = 1'b1;
        end
        S_ALU4: begin
          Bus2_Sel = 2'b00;
          CCR_Load = 1'b1;
          ALU_Sel  = alu_code;
          A_Load   = ~alu_dest_b;
          B_Load   = alu_dest_b;
        end
        S_BT6: begin
          Bus2_Sel = 2'b10;
          PC_Load  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; all opcodes SHALL be fixed constants matching the CPU instruction set.
REQ-002 clk  input  1  single system clock; all state changes SHALL occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 IR  input  8  current opcode from the instruction register.
REQ-005 CCR_Result  input  4  condition flags {N,Z,V,C}, bit3=N, bit2=Z, bit1=V, bit0=C.
REQ-006 IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write  output  1 each  datapath strobes.
REQ-007 ALU_Sel  output  4  ALU operation select.
REQ-008 Bus1_Sel  output  2  00=PC, 01=A, 10=B.
REQ-009 Bus2_Sel  output  2  00=ALU result, 01=Bus1, 10=memory data.

Function
REQ-010 The block SHALL be a Moore FSM; outputs SHALL depend only on the current state, plus IR for ALU_Sel and A_Load/B_Load.
REQ-011 Memory is synchronous; every read SHALL have one wait state between MAR_Load and consuming memory data.
REQ-012 Fetch: F0 drives Bus1=PC, Bus2=Bus1, MAR_Load; F1 drives PC_Inc; F2 drives Bus2=mem, IR_Load; D3 drives no strobes and selects the execute path from IR.
REQ-013 LDA_IMM 86h / LDB_IMM 88h SHALL:
- E4: MAR<-PC.
- E5: PC_Inc.
- E6: Bus2=mem, A_Load (86h) or B_Load (88h).
- Return to F0; 7 cycles total.
REQ-014 LDA_DIR 87h / LDB_DIR 89h SHALL:
- E4: MAR<-PC.
- E5: PC_Inc.
- E6: Bus2=mem, MAR_Load.
- E7: wait.
- E8: Bus2=mem, A_Load or B_Load.
- 9 cycles total.
REQ-015 STA_DIR 96h / STB_DIR 97h / STR_DIR 98h SHALL:
- E4–E6 as in REQ-014.
- E7: write=1, Bus2=Bus1 with Bus1=A (96h) or B (97h), or Bus2=ALU result (98h).
- 8 cycles total.
REQ-016 ALU ops SHALL take E4 only: Bus2=ALU, CCR_Load=1, ALU_Sel per REQ-017, 5 cycles total.
- Destination A for opcodes 42h–4Bh; destination B for 4Ch–4Fh.
REQ-017 ALU_Sel mapping (opcode -> code):
- 42->0 A+B, 43->1 A-B, 44->2 A&B, 45->3 A|B.
- 46->4 A+1, 48->5 A-1, 4A->6 A^B, 4B->7 ~A.
- 4C->8 B+1, 4D->9 B-1, 4E->10 ~B, 4F->11 B-A.
- ALU_Sel SHALL be 0 in non-ALU states.
REQ-018 Branch taken is evaluated in D3:
- 20h: always taken.
- 21h/22h: taken if N=1 / N=0.
- 23h/24h: taken if Z=1 / Z=0.
- 25h/26h: taken if V=1 / V=0.
- 27h/28h: taken if C=1 / C=0.
REQ-019 Taken branch SHALL: E4 MAR<-PC; E5 wait; E6 Bus2=mem, PC_Load; 7 cycles total.
REQ-020 Not-taken branch SHALL: E4 PC_Inc only (skip operand); 5 cycles total.
REQ-021 Any undefined opcode SHALL execute as NOP: D3 returns directly to F0; 4 cycles total.
REQ-022 CCR_Result SHALL be sampled only in D3; flag changes in other states SHALL have no effect.
REQ-023 At most one of PC_Load/PC_Inc, and at most one of A_Load/B_Load, SHALL be asserted in any state.
REQ-024 write SHALL be asserted for exactly one cycle per store, and never otherwise.
REQ-025 After the last state of any instruction, the next state SHALL be F0; instructions SHALL run back-to-back with no idle cycles.

Reset
REQ-026 While reset=1, the state SHALL be F0 immediately (asynchronous) and every output SHALL be 0, including ALU_Sel and the bus selects.
REQ-027 On the first rising clk edge after reset deasserts, the FSM SHALL be in F0 with F0 outputs active.
REQ-028 Reset asserted in any state, including mid-store (E7), SHALL abort the instruction; write SHALL drop to 0 asynchronously.

Verification
REQ-029 Release reset, IR=86h -> F0..E6 over 7 cycles; IR_Load in cycle 3; A_Load only in cycle 7; then F0.
REQ-030 IR=43h -> cycle 5 has ALU_Sel=1, Bus2_Sel=00, A_Load=1, CCR_Load=1; IR=4Fh -> ALU_Sel=11, B_Load=1.
REQ-031 IR=23h:
- with Z=1 in D3 -> PC_Load asserted in cycle 7.
- with Z=0 in D3 -> PC_Inc in cycle 5, next cycle is F0.
REQ-032 IR=98h -> single write=1 cycle (cycle 8) with Bus2_Sel=00; IR=96h -> Bus1_Sel=01, Bus2_Sel=01 at write.
REQ-033 IR=FFh -> no strobes after IR_Load; F0 again in cycle 5.
REQ-034 Assert reset mid-cycle during E7 of STA -> write and all outputs go 0 before the next edge; after release, F0 begins.
